// File: rtl/sram_arbiter.sv
// Time-slotted SRAM arbiter: even cycles launch a display read, odd cycles drain one buffered draw write.
// Optional SRAM_BYTE_MASK_EN macro stores wr_be and drives UB_N/LB_N from it in the write slot.
module sram_arbiter #(
    parameter int WR_FIFO_DEPTH = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [19:0] sram_read_address,
    input  logic [19:0] sram_write_address,
    input  logic        wr_req,
    input  logic [15:0] wr_data,
    input  logic [1:0]  wr_be,
    output logic        wr_ready,
    output logic        wr_done,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic [19:0] SRAM_ADDR,
    input  logic [15:0] SRAM_DQ_in,
    output logic [15:0] SRAM_DQ_out,
    output logic        SRAM_DQ_oe,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);
    localparam int PW = $clog2(WR_FIFO_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(WR_FIFO_DEPTH);

    typedef enum logic {
        READ_SLOT  = 1'b0,
        WRITE_SLOT = 1'b1
    } phase_t;

    typedef struct packed {
        logic [19:0] addr;
        logic [15:0] data;
`ifdef SRAM_BYTE_MASK_EN
        logic [1:0]  be;
`endif
    } wr_entry_t;

    phase_t        phase, phase_next;
    wr_entry_t     fifo [WR_FIFO_DEPTH];
    wr_entry_t     head, entry_in;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count, count_next;
    logic          push, pop;

`ifndef SRAM_BYTE_MASK_EN
    logic unused_be;
    assign unused_be = ^wr_be;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) phase <= READ_SLOT;
        else       phase <= phase_next;
    end

    always_comb begin
        phase_next = READ_SLOT;
        if (phase == READ_SLOT) phase_next = WRITE_SLOT;
    end

    always_comb begin
        entry_in      = '0;
        entry_in.addr = sram_write_address;
        entry_in.data = wr_data;
`ifdef SRAM_BYTE_MASK_EN
        entry_in.be   = wr_be;
`endif
        head  = fifo[rd_ptr];
        // wr_ready is the registered "not full", so a push can never land on a full buffer
        push  = wr_req && wr_ready;
        pop   = (phase == WRITE_SLOT) && (count != '0);
        count_next = count;
        if (push && !pop)      count_next = count + 1'b1;
        else if (!push && pop) count_next = count - 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (!Reset && push) fifo[wr_ptr] <= entry_in;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            wr_ready    <= 1'b0;
            wr_done     <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            SRAM_ADDR   <= '0;
            SRAM_DQ_out <= '0;
            SRAM_DQ_oe  <= 1'b0;
            SRAM_CE_N   <= 1'b1;
            SRAM_OE_N   <= 1'b1;
            SRAM_WE_N   <= 1'b1;
            SRAM_UB_N   <= 1'b1;
            SRAM_LB_N   <= 1'b1;
        end else begin
            count    <= count_next;
            wr_ready <= (count_next != FULL);
            // pulse the cycle after the write strobe was on the pins
            wr_done  <= ~SRAM_WE_N;
            rd_valid <= 1'b0;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            SRAM_CE_N <= 1'b0;
            SRAM_UB_N <= 1'b0;
            SRAM_LB_N <= 1'b0;
            if (phase == READ_SLOT) begin
                SRAM_ADDR  <= sram_read_address;
                SRAM_OE_N  <= 1'b0;
                SRAM_WE_N  <= 1'b1;
                SRAM_DQ_oe <= 1'b0;
            end else begin
                // data for the read launched last edge is on the bus now
                rd_data   <= SRAM_DQ_in;
                rd_valid  <= 1'b1;
                SRAM_OE_N <= 1'b1;
                if (pop) begin
                    SRAM_ADDR   <= head.addr;
                    SRAM_DQ_out <= head.data;
                    SRAM_DQ_oe  <= 1'b1;
                    SRAM_WE_N   <= 1'b0;
`ifdef SRAM_BYTE_MASK_EN
                    SRAM_UB_N   <= ~head.be[1];
                    SRAM_LB_N   <= ~head.be[0];
`endif
                end else begin
                    SRAM_WE_N  <= 1'b1;
                    SRAM_DQ_oe <= 1'b0;
                end
            end
        end
    end
endmodule
